// File: rtl/scmp_useq_pkg.sv
// Shared definitions for the SC/MP microcode sequencer: default widths,
// control-bit positions of the PLA sequencing fields and condition evaluation.
package scmp_useq_pkg;

   localparam int DEF_PC_W    = 8;
   localparam int DEF_NXT_W   = 6;
   localparam int DEF_COND_W  = 4;
   localparam int DEF_STACK_D = 2;

   // Condition vectors are zero-extended to this width before evaluation;
   // zero mask bits never contribute, so widening is transparent.
   localparam int COND_MAX_W = 16;

   // Bit positions inside the packed {ret, call, decode} control word
   localparam int CTL_W      = 3;
   localparam int CTL_DECODE = 0;
   localparam int CTL_CALL   = 1;
   localparam int CTL_RET    = 2;

   // Selected condition is true when any masked flag differs from its polarity bit
   function automatic logic cond_eval(input logic [COND_MAX_W-1:0] cond_in,
                                      input logic [COND_MAX_W-1:0] condx,
                                      input logic [COND_MAX_W-1:0] condm);
      return |((cond_in ^ condx) & condm);
   endfunction

endpackage

// File: rtl/scmp_useq_if.sv
// Sequencer <-> PLA/bus interface. The master side (PLA, opcode decoder,
// bus controller) drives the fields; the slave side is the sequencer.
interface scmp_useq_if
   import scmp_useq_pkg::*;
#(
   parameter int PC_W    = DEF_PC_W,
   parameter int NXT_W   = DEF_NXT_W,
   parameter int COND_W  = DEF_COND_W,
   parameter int STACK_D = DEF_STACK_D
);
   localparam int DEPTH_W = $clog2(STACK_D + 1);

   logic                 stall;
   logic [COND_W-1:0]    cond_in;
   logic [PC_W-1:0]      op_pc;
   logic [NXT_W-1:0]     mi_nxt;
   logic [COND_W-1:0]    mi_condm;
   logic [COND_W-1:0]    mi_condx;
   logic                 mi_decode;
   logic                 mi_call;
   logic                 mi_ret;
   logic [PC_W-1:0]      upc;
   logic [DEPTH_W-1:0]   depth;
   logic                 stack_err;

   modport master (
      output stall, cond_in, op_pc, mi_nxt, mi_condm, mi_condx,
             mi_decode, mi_call, mi_ret,
      input  upc, depth, stack_err
   );

   modport slave (
      input  stall, cond_in, op_pc, mi_nxt, mi_condm, mi_condx,
             mi_decode, mi_call, mi_ret,
      output upc, depth, stack_err
   );

endinterface

// File: rtl/scmp_useq_stack.sv
// Return-address LIFO: fixed storage addressed by an occupancy counter,
// entries never move. Push when full and pop when empty are ignored here;
// the caller flags those as errors.
module scmp_useq_stack
#(
   parameter  int PC_W    = 8,
   parameter  int STACK_D = 2,
   localparam int DEPTH_W = $clog2(STACK_D + 1)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic [PC_W-1:0]    i_data,
   output logic [PC_W-1:0]    o_top,
   output logic               o_full,
   output logic               o_empty,
   output logic [DEPTH_W-1:0] o_depth
);

   logic [PC_W-1:0]    r_mem [STACK_D];
   logic [DEPTH_W-1:0] r_cnt;
   logic [DEPTH_W-1:0] w_top_idx;

   assign w_top_idx = r_cnt - DEPTH_W'(1);
   assign o_full    = (r_cnt == DEPTH_W'(STACK_D));
   assign o_empty   = (r_cnt == DEPTH_W'(0));
   assign o_depth   = r_cnt;

   // Read the most recently pushed entry (don't-care zero when empty)
   always_comb begin
      o_top = '0;
      for (int i = 0; i < STACK_D; i++) begin
         o_top = (DEPTH_W'(i) == w_top_idx) ? r_mem[i] : o_top;
      end
   end

   // Storage and occupancy counter; push takes precedence if both requested
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         for (int i = 0; i < STACK_D; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_push && !o_full) begin
         for (int i = 0; i < STACK_D; i++) begin
            if (DEPTH_W'(i) == r_cnt) begin
               r_mem[i] <= i_data;
            end
         end
         r_cnt <= r_cnt + DEPTH_W'(1);
      end else if (i_pop && !o_empty) begin
         r_cnt <= r_cnt - DEPTH_W'(1);
      end
   end

endmodule

// File: rtl/scmp_useq.sv
// SC/MP microcode sequencer: holds the uPC and picks the next microinstruction
// address from opcode dispatch, condition skip, return stack or relative jump.
// One microinstruction per unstalled cycle; stall freezes everything.
module scmp_useq
   import scmp_useq_pkg::*;
#(
   parameter  int PC_W    = DEF_PC_W,
   parameter  int NXT_W   = DEF_NXT_W,
   parameter  int COND_W  = DEF_COND_W,
   parameter  int STACK_D = DEF_STACK_D,
   localparam int DEPTH_W = $clog2(STACK_D + 1)
)(
   input  logic         clk,
   input  logic         rst_n,
   scmp_useq_if.slave   bus
);

   logic [PC_W-1:0]    r_upc;
   logic               r_stack_err;

   logic [PC_W-1:0]    w_upc_nxt;
   logic [PC_W-1:0]    w_upc_inc;
   logic [PC_W-1:0]    w_upc_rel;
   logic [PC_W-1:0]    w_rel_off;
   logic [CTL_W-1:0]   w_ctl;
   logic               w_cond;
   logic               w_push;
   logic               w_pop;
   logic               w_err_set;
   logic [PC_W-1:0]    w_top;
   logic               w_full;
   logic               w_empty;
   logic [DEPTH_W-1:0] w_depth;

   assign w_ctl     = {bus.mi_ret, bus.mi_call, bus.mi_decode};
   assign w_cond    = cond_eval(COND_MAX_W'(bus.cond_in),
                                COND_MAX_W'(bus.mi_condx),
                                COND_MAX_W'(bus.mi_condm));
   assign w_rel_off = PC_W'($signed(bus.mi_nxt));
   assign w_upc_inc = r_upc + PC_W'(1);
   assign w_upc_rel = r_upc + w_rel_off;

   // Next-address priority: decode, condition skip, return, call, zero, relative
   always_comb begin
      w_upc_nxt = r_upc;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_err_set = 1'b0;
      if (bus.stall) begin
         w_upc_nxt = r_upc;
      end else if (w_ctl[CTL_DECODE]) begin
         w_upc_nxt = bus.op_pc;
      end else if (w_cond) begin
         w_upc_nxt = w_upc_inc;
      end else if (w_ctl[CTL_RET]) begin
         if (!w_empty) begin
            w_upc_nxt = w_top;
            w_pop     = 1'b1;
         end else begin
            w_upc_nxt = '0;
            w_err_set = 1'b1;
         end
      end else if (w_ctl[CTL_CALL]) begin
         w_upc_nxt = w_upc_rel;
         if (!w_full) begin
            w_push = 1'b1;
         end else begin
            w_err_set = 1'b1;
         end
      end else if (bus.mi_nxt == NXT_W'(0)) begin
         w_upc_nxt = '0;
      end else begin
         w_upc_nxt = w_upc_rel;
      end
   end

   // uPC register and sticky stack error flag (cleared only by reset)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_upc       <= '0;
         r_stack_err <= 1'b0;
      end else begin
         r_upc       <= w_upc_nxt;
         r_stack_err <= r_stack_err | w_err_set;
      end
   end

   scmp_useq_stack #(
      .PC_W    (PC_W),
      .STACK_D (STACK_D)
   ) u_stack (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_upc_inc),
      .o_top   (w_top),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_depth (w_depth)
   );

   assign bus.upc       = r_upc;
   assign bus.depth     = w_depth;
   assign bus.stack_err = r_stack_err;

endmodule

// File: doc/scmp_useq.md
# scmp_useq

Parametrised microcode sequencer for the SC/MP core: holds the microprogram counter (uPC), selects the next microinstruction address from the opcode dispatch, a multi-bit condition test, a signed relative jump, or a return/subroutine stack, and stalls on bus wait. It drives the address input of the microcode PLA/ROM and takes that PLA's sequencing fields back combinationally. Datapath control fields (ld/rd/wr/alu) bypass this block.

## Interface
- PC_W, 8, uPC width; microcode space 2^PC_W words
- NXT_W, 6, width of signed relative-jump field (two's complement)
- COND_W, 4, number of condition inputs
- STACK_D, 2, return-stack depth (≥1)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  bus not ready; freezes sequencer
- cond_in  in  COND_W  live condition flags (op[7], carry, zero, sense etc.)
- op_pc  in  PC_W  dispatch address from opcode decoder
- mi_nxt  in  NXT_W  signed jump from PLA; 0 = go to address 0
- mi_condm  in  COND_W  condition mask from PLA
- mi_condx  in  COND_W  condition polarity XOR from PLA
- mi_decode  in  1  dispatch to op_pc
- mi_call  in  1  push return address, jump relative
- mi_ret  in  1  pop return address
- upc  out  PC_W  current uPC to PLA
- depth  out  $clog2(STACK_D+1)  stack occupancy
- stack_err  out  1  sticky overflow/underflow flag

## Operation
- cond = |((cond_in ^ mi_condx) & mi_condm); mask 0 ⇒ cond=0.
- Next-state priority per enabled cycle (stall=0):
  1. mi_decode: upc ← op_pc (unconditional; cond ignored).
  2. cond=1: upc ← upc+1 (skips call/ret/jump; makes them conditional).
  3. mi_ret: if depth>0 upc ← top, depth−1; if empty upc ← 0, stack_err←1.
  4. mi_call: push upc+1, upc ← upc+sext(mi_nxt); if full, push dropped, stack_err←1, jump still taken.
  5. mi_nxt==0: upc ← 0.
  6. else upc ← upc+sext(mi_nxt).
- mi_call and mi_ret both set: mi_ret wins; call ignored.
- All uPC arithmetic modulo 2^PC_W (wraps, no flag); return address upc+1 also wraps.
- stall=1: upc, stack, depth, stack_err hold; no field acted upon.
- stack_err cleared only by reset.

## Timing
- Reset (async assert, sync-safe deassert): upc=0, depth=0, stack_err=0, stack entries 0.
- upc registered; PLA fields combinational from upc within the same cycle; decision applied on next posedge → one microinstruction per unstalled cycle.
- depth and stack_err update on the same edge as upc.
- stall sampled at posedge; a cycle with stall=1 repeats the current microinstruction.
- Reset mid-call/mid-stall: everything returns to reset values; no stack contents preserved.

## Structure
- Package scmp_useq_pkg: localparams for default widths, mi ctl bit indices (CTL_DECODE, CTL_CALL, CTL_RET), and a cond_eval function.
- Sub-module scmp_useq_stack: LIFO of STACK_D × PC_W with push/pop/full/empty/depth; pointer-based, no shifting.
- Top: cond logic, priority mux, uPC register, error flag.

## Test plan
- Reset then mi_nxt=3, no cond, 3 cycles → upc 0,3,6,9; stack_err=0.
- upc=0x10, mi_condm=0001, mi_condx=0000, cond_in[0]=1, mi_nxt=5 → upc=0x11; cond_in[0]=0 → upc=0x15.
- upc=0x20 mi_call, mi_nxt=0x10 → upc=0x30, depth=1; later mi_ret → upc=0x21, depth=0.
- STACK_D=2: three calls → depth=2, stack_err=1, third jump taken; ret on empty → upc=0, stack_err stays 1.
- upc=0xFE, mi_nxt=+4 → upc=0x02; mi_nxt=−3 from 0x01 → 0xFE.
- mi_decode with op_pc=0x40 while stall=1 for 2 cycles → upc unchanged, then 0x40 on first unstalled edge; assert rst_n low mid-stall → upc=0, depth=0.
